// File: rtl/dh_key_sequencer.sv
// dh_key_sequencer
//
// Purpose:
//   Operand-entry and job controller for a small Diffie-Hellman demo.
//   Decoded PS/2 set-2 scancodes enter the modulus p, base g and the two
//   secrets a and b. One shared modular-exponentiation engine then computes
//   A_pub = g^a mod p, B_pub = g^b mod p and the shared key K = B_pub^a mod p
//   (plus K2 = A_pub^b mod p when verification is built).
//
// Build option:
//   KEY_VERIFY_EN - when defined, the EXP_KB job and the K2 register are
//                   built. key_match then reports K == K2, and a mismatch
//                   gives a one-cycle err pulse on entry to SHOW. When it is
//                   undefined, EXP_KA goes straight to SHOW and key_match is 1.
//
// Ports:
//   CLK, RST_N            clock (rising edge), synchronous active-low reset
//   key_valid, key_code   one-cycle strobe plus raw scancode byte
//   mx_start              one-cycle engine start pulse
//   mx_base/exp/mod       engine operands, held from start until done
//   mx_done, mx_result    engine completion pulse and its result
//   disp_val              value shown on the display
//   state_code            current state encoding
//   key_match             both parties' keys agree (valid in SHOW)
//   err                   high while in ERR (and the mismatch pulse)

module dh_key_sequencer #(
  parameter int W       = 4,
  parameter int TIMEOUT = 255
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         key_valid,
  input  logic [7:0]   key_code,
  output logic         mx_start,
  output logic [W-1:0] mx_base,
  output logic [W-1:0] mx_exp,
  output logic [W-1:0] mx_mod,
  input  logic         mx_done,
  input  logic [W-1:0] mx_result,
  output logic [W-1:0] disp_val,
  output logic [3:0]   state_code,
  output logic         key_match,
  output logic         err
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'h0,
    S_GET_P  = 4'h1,
    S_GET_G  = 4'h2,
    S_GET_A  = 4'h3,
    S_GET_B  = 4'h4,
    S_EXP_A  = 4'h5,
    S_EXP_B  = 4'h6,
    S_EXP_KA = 4'h7,
    S_EXP_KB = 4'h8,
    S_SHOW   = 4'h9,
    S_ERR    = 4'hF
  } state_t;

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_A     = 8'h1C;
  localparam logic [7:0] CODE_B     = 8'h32;
  localparam logic [7:0] CODE_C     = 8'h21;
  localparam logic [7:0] CODE_E     = 8'h24;

  // Scancodes for digits 0..9, indexed by digit value.
  localparam logic [7:0] DIGIT_CODE [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
  };

  // Last watchdog count before the timeout edge: ERR lands exactly
  // TIMEOUT cycles after the cycle in which mx_start was high.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t       state_q, state_d;
  logic [W-1:0] p_q, p_d, g_q, g_d, a_q, a_d, b_q, b_d;
  logic [W-1:0] apub_q, apub_d, bpub_q, bpub_d, k_q, k_d;
`ifdef KEY_VERIFY_EN
  logic [W-1:0] k2_q, k2_d;
`endif
  logic         brk_q, brk_d;
  logic [7:0]   wdog_q, wdog_d;
  logic [1:0]   sel_q, sel_d;
  logic         mx_start_q, mx_start_d;
  logic [W-1:0] mx_base_q, mx_base_d, mx_exp_q, mx_exp_d, mx_mod_q, mx_mod_d;
  logic [W-1:0] disp_val_q, disp_val_d;
  logic         key_match_q, key_match_d;
  logic         err_q, err_d;

  // Scancode decode
  logic [9:0]   dig_hit;
  logic [W-1:0] dig_val;
  logic         key_ev, key_dig, key_a, key_b, key_c, key_e;
  logic         match_new;
  logic         bad_operands;

  for (genvar gi = 0; gi < 10; gi++) begin : g_digit_dec
    assign dig_hit[gi] = (key_code == DIGIT_CODE[gi]);
  end

  always_comb begin
    dig_val = '0;
    for (int i = 1; i < 10; i++) begin
      if (dig_hit[i]) dig_val = W'(i);
    end
  end

  // A byte following F0 is the release half of a make/break pair and is
  // swallowed, so only fresh make codes become key events.
  assign key_ev  = key_valid && !brk_q && (key_code != CODE_BREAK);
  // Digit 0 never reaches a register: every operand must be non-zero.
  assign key_dig = key_ev && (|dig_hit[9:1]);
  assign key_a   = key_ev && (key_code == CODE_A);
  assign key_b   = key_ev && (key_code == CODE_B);
  assign key_c   = key_ev && (key_code == CODE_C);
  assign key_e   = key_ev && (key_code == CODE_E);

  assign bad_operands = (p_q < W'(2)) || (g_q >= p_q) ||
                        (g_q == '0) || (a_q == '0) || (b_q == '0);

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    g_d        = g_q;
    a_d        = a_q;
    b_d        = b_q;
    apub_d     = apub_q;
    bpub_d     = bpub_q;
    k_d        = k_q;
`ifdef KEY_VERIFY_EN
    k2_d       = k2_q;
`endif
    brk_d      = brk_q;
    wdog_d     = wdog_q;
    sel_d      = sel_q;
    mx_start_d = 1'b0;
    mx_base_d  = mx_base_q;
    mx_exp_d   = mx_exp_q;
    mx_mod_d   = mx_mod_q;
    match_new  = 1'b1;

    if (key_valid) brk_d = brk_q ? 1'b0 : (key_code == CODE_BREAK);

    case (state_q)
      S_IDLE: begin
        if (key_b) state_d = S_GET_P;
      end
      S_GET_P: begin
        if (key_dig) p_d = dig_val;
        if (key_a) state_d = S_GET_G;
        if (key_e) state_d = S_IDLE;
      end
      S_GET_G: begin
        if (key_dig) g_d = dig_val;
        if (key_a) state_d = S_GET_A;
        if (key_e) state_d = S_IDLE;
      end
      S_GET_A: begin
        if (key_dig) a_d = dig_val;
        if (key_a) state_d = S_GET_B;
        if (key_e) state_d = S_IDLE;
      end
      S_GET_B: begin
        if (key_dig) b_d = dig_val;
        if (key_e) state_d = S_IDLE;
        if (key_c) begin
          if (bad_operands) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_EXP_A;
            mx_start_d = 1'b1;
            mx_base_d  = g_q;
            mx_exp_d   = a_q;
            mx_mod_d   = p_q;
            wdog_d     = '0;
          end
        end
      end
      // In the EXP states done takes priority over an expiring watchdog.
      S_EXP_A: begin
        if (mx_done) begin
          apub_d     = mx_result;
          state_d    = S_EXP_B;
          mx_start_d = 1'b1;
          mx_base_d  = g_q;
          mx_exp_d   = b_q;
          wdog_d     = '0;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = S_ERR;
          wdog_d  = '0;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      S_EXP_B: begin
        if (mx_done) begin
          bpub_d     = mx_result;
          state_d    = S_EXP_KA;
          mx_start_d = 1'b1;
          mx_base_d  = mx_result;
          mx_exp_d   = a_q;
          wdog_d     = '0;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = S_ERR;
          wdog_d  = '0;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      S_EXP_KA: begin
        if (mx_done) begin
          k_d = mx_result;
`ifdef KEY_VERIFY_EN
          state_d    = S_EXP_KB;
          mx_start_d = 1'b1;
          mx_base_d  = apub_q;
          mx_exp_d   = b_q;
          wdog_d     = '0;
`else
          state_d = S_SHOW;
          sel_d   = 2'd0;
`endif
        end else if (wdog_q == WDOG_LAST) begin
          state_d = S_ERR;
          wdog_d  = '0;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
`ifdef KEY_VERIFY_EN
      S_EXP_KB: begin
        if (mx_done) begin
          k2_d      = mx_result;
          state_d   = S_SHOW;
          sel_d     = 2'd0;
          match_new = (k_q == mx_result);
        end else if (wdog_q == WDOG_LAST) begin
          state_d = S_ERR;
          wdog_d  = '0;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
`endif
      S_SHOW: begin
        // Display cycles K -> A_pub -> B_pub -> K.
        if (key_a) sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
        if (key_e) state_d = S_IDLE;
      end
      S_ERR: begin
        if (key_e) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are derived from the next-state values so they
    // line up with state_code on the same edge.
    case (state_d)
      S_GET_P: disp_val_d = p_d;
      S_GET_G: disp_val_d = g_d;
      S_GET_A: disp_val_d = a_d;
      S_GET_B: disp_val_d = b_d;
      S_SHOW: begin
        case (sel_d)
          2'd1:    disp_val_d = apub_d;
          2'd2:    disp_val_d = bpub_d;
          default: disp_val_d = k_d;
        endcase
      end
      default: disp_val_d = '0;
    endcase

    key_match_d = 1'b0;
    if (state_d == S_SHOW) begin
`ifdef KEY_VERIFY_EN
      key_match_d = (state_q == S_SHOW) ? (k_q == k2_q) : match_new;
`else
      key_match_d = (state_q == S_SHOW) ? 1'b1 : match_new;
`endif
    end

    err_d = (state_d == S_ERR) ||
            ((state_q != S_SHOW) && (state_d == S_SHOW) && !match_new);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      p_q         <= '0;
      g_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      apub_q      <= '0;
      bpub_q      <= '0;
      k_q         <= '0;
`ifdef KEY_VERIFY_EN
      k2_q        <= '0;
`endif
      brk_q       <= 1'b0;
      wdog_q      <= '0;
      sel_q       <= '0;
      mx_start_q  <= 1'b0;
      mx_base_q   <= '0;
      mx_exp_q    <= '0;
      mx_mod_q    <= '0;
      disp_val_q  <= '0;
      key_match_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      g_q         <= g_d;
      a_q         <= a_d;
      b_q         <= b_d;
      apub_q      <= apub_d;
      bpub_q      <= bpub_d;
      k_q         <= k_d;
`ifdef KEY_VERIFY_EN
      k2_q        <= k2_d;
`endif
      brk_q       <= brk_d;
      wdog_q      <= wdog_d;
      sel_q       <= sel_d;
      mx_start_q  <= mx_start_d;
      mx_base_q   <= mx_base_d;
      mx_exp_q    <= mx_exp_d;
      mx_mod_q    <= mx_mod_d;
      disp_val_q  <= disp_val_d;
      key_match_q <= key_match_d;
      err_q       <= err_d;
    end
  end

  assign mx_start   = mx_start_q;
  assign mx_base    = mx_base_q;
  assign mx_exp     = mx_exp_q;
  assign mx_mod     = mx_mod_q;
  assign disp_val   = disp_val_q;
  assign state_code = state_q;
  assign key_match  = key_match_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dh_key_sequencer.sv
// Directed testbench for dh_key_sequencer. A small engine model answers
// each mx_start ten cycles later; every check uses hand-computed values.
// Build with or without KEY_VERIFY_EN to match the design build.

module tb_dh_key_sequencer;

  localparam int W = 4;

  logic         CLK;
  logic         RST_N;
  logic         key_valid;
  logic [7:0]   key_code;
  logic         mx_start;
  logic [W-1:0] mx_base, mx_exp, mx_mod;
  logic         mx_done;
  logic [W-1:0] mx_result;
  logic [W-1:0] disp_val;
  logic [3:0]   state_code;
  logic         key_match;
  logic         err;

  int total = 0;
  int bad   = 0;

  // engine model state
  logic        eng_on      = 1'b1;
  logic        eng_corrupt = 1'b0;
  int          job_cnt     = 0;
  int          done_cnt    = 0;
  int          unstable    = 0;
  logic [3:0]  jb_base [32];
  logic [3:0]  jb_exp  [32];
  logic [3:0]  jb_mod  [32];

  dh_key_sequencer #(.W(W), .TIMEOUT(255)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .mx_start   (mx_start),
    .mx_base    (mx_base),
    .mx_exp     (mx_exp),
    .mx_mod     (mx_mod),
    .mx_done    (mx_done),
    .mx_result  (mx_result),
    .disp_val   (disp_val),
    .state_code (state_code),
    .key_match  (key_match),
    .err        (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [3:0] modexp(input logic [3:0] b, input logic [3:0] e,
                                        input logic [3:0] m);
    int r;
    r = 1;
    if (m == 0) return 4'd0;
    for (int i = 0; i < int'(e); i++) r = (r * int'(b)) % int'(m);
    return 4'(r % int'(m));
  endfunction

  // Engine model: answers ten cycles after the mx_start cycle.
  initial begin
    logic [3:0] cb, ce, cm, r;
    mx_done   = 1'b0;
    mx_result = '0;
    @(posedge CLK); #1;
    forever begin
      if (mx_start === 1'b1) begin
        cb = mx_base; ce = mx_exp; cm = mx_mod;
        if (job_cnt < 32) begin
          jb_base[job_cnt] = cb;
          jb_exp[job_cnt]  = ce;
          jb_mod[job_cnt]  = cm;
        end
        r = modexp(cb, ce, cm);
        if (eng_corrupt && job_cnt == 3) r = 4'd3;
        job_cnt++;
        repeat (9) @(posedge CLK);
        #1;
        if (mx_base !== cb || mx_exp !== ce || mx_mod !== cm) unstable++;
        if (eng_on) begin
          mx_done   = 1'b1;
          mx_result = r;
          done_cnt++;
        end
        @(posedge CLK); #1;
        mx_done = 1'b0;
      end else begin
        @(posedge CLK); #1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic press(input logic [7:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(posedge CLK); #1;
    key_valid = 1'b0;
    key_code  = 8'h00;
  endtask

  // Wait (bounded) until state_code reaches s; returns found flag.
  task automatic wait_state(input logic [3:0] s, input int limit, output logic found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(posedge CLK); #1;
      if (state_code == s) found = 1'b1;
    end
  endtask

  localparam logic [7:0] K0 = 8'h45, K1 = 8'h16, K2 = 8'h1E, K3 = 8'h26,
                         K4 = 8'h25, K5 = 8'h2E, K6 = 8'h36, K7 = 8'h3D,
                         K9 = 8'h46;
  localparam logic [7:0] KA = 8'h1C, KB = 8'h32, KC = 8'h21, KE = 8'h24, KF0 = 8'hF0;

  initial begin
    logic found;
    int   jobs_before, dones_before;

    RST_N     = 1'b0;
    key_valid = 1'b0;
    key_code  = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_state", state_code, 4'h0);
    chk("rst_disp", disp_val, 4'h0);
    chk("rst_start", mx_start, 1'b0);
    chk("rst_match", key_match, 1'b0);
    chk("rst_err", err, 1'b0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Scenario 1: p=7 g=3 a=2 b=4
    press(KB);  chk("s1_get_p", state_code, 4'h1);
    press(K7);  chk("s1_p_disp", disp_val, 4'h7);
    press(KA);  chk("s1_get_g", state_code, 4'h2);
    chk("s1_g_init", disp_val, 4'h0);
    press(K3);  chk("s1_g_disp", disp_val, 4'h3);
    press(KA);  press(K2); chk("s1_a_disp", disp_val, 4'h2);
    press(KA);  press(K4); chk("s1_b_disp", disp_val, 4'h4);
    chk("s1_get_b", state_code, 4'h4);
    press(KC);
    chk("s1_exp_a", state_code, 4'h5);
    chk("s1_start_hi", mx_start, 1'b1);
    chk("s1_op_base", mx_base, 4'h3);
    chk("s1_op_exp", mx_exp, 4'h2);
    chk("s1_op_mod", mx_mod, 4'h7);
    chk("s1_exp_disp", disp_val, 4'h0);
    @(posedge CLK); #1;
    chk("s1_start_lo", mx_start, 1'b0);
    wait_state(4'h9, 200, found);
    chk("s1_show_reached", found, 1'b1);
    chk("s1_show_err", err, 1'b0);
    chk("s1_show_k", disp_val, 4'h2);
    chk("s1_match", key_match, 1'b1);
`ifdef KEY_VERIFY_EN
    chk("s1_jobs", job_cnt, 4);
    chk("s1_job3", {jb_base[3], jb_exp[3], jb_mod[3]}, 12'h247);
`else
    chk("s1_jobs", job_cnt, 3);
`endif
    chk("s1_job0", {jb_base[0], jb_exp[0], jb_mod[0]}, 12'h327);
    chk("s1_job1", {jb_base[1], jb_exp[1], jb_mod[1]}, 12'h347);
    chk("s1_job2", {jb_base[2], jb_exp[2], jb_mod[2]}, 12'h427);
    chk("s1_ops_stable", unstable, 0);
    press(KA);  chk("s1_cyc_apub", disp_val, 4'h2);
    press(KA);  chk("s1_cyc_bpub", disp_val, 4'h4);
    press(KA);  chk("s1_cyc_k", disp_val, 4'h2);
    chk("s1_show_hold", state_code, 4'h9);
    press(KE);
    chk("s1_abort_state", state_code, 4'h0);
    chk("s1_abort_match", key_match, 1'b0);

    // Scenario 2: p=1 -> ERR without starting the engine
    jobs_before = job_cnt;
    press(KB); press(K1); press(KA); press(K3); press(KA); press(K2);
    press(KA); press(K4); press(KC);
    chk("s2_err_state", state_code, 4'hF);
    chk("s2_err_flag", err, 1'b1);
    chk("s2_err_disp", disp_val, 4'h0);
    repeat (3) @(posedge CLK);
    #1;
    chk("s2_no_start", job_cnt, jobs_before);
    press(KA);  chk("s2_a_ignored", state_code, 4'hF);
    press(KE);
    chk("s2_clear_state", state_code, 4'h0);
    chk("s2_clear_err", err, 1'b0);

    // Scenario 3: g>=p, plus digit 0 rejected in GET_A
    press(KB); press(K5); press(KA); press(K6); press(KA);
    press(K3);  chk("s3_a_disp", disp_val, 4'h3);
    press(K0);  chk("s3_zero_rej", disp_val, 4'h3);
    chk("s3_zero_state", state_code, 4'h3);
    press(KA); press(K4); press(KC);
    chk("s3_err_state", state_code, 4'hF);
    chk("s3_err_flag", err, 1'b1);
    press(KE);

    // Scenario 4: engine silent -> timeout 255 cycles after mx_start
    press(KB); press(K7); press(KA); press(K3); press(KA); press(K2);
    press(KA); press(K4);
    eng_on = 1'b0;
    press(KC);
    chk("s4_start", mx_start, 1'b1);
    press(KE);
    chk("s4_e_ignored", state_code, 4'h5);
    repeat (253) @(posedge CLK);
    #1;
    chk("s4_pre_timeout", state_code, 4'h5);
    @(posedge CLK); #1;
    chk("s4_timeout_state", state_code, 4'hF);
    chk("s4_timeout_err", err, 1'b1);
    press(KE);
    chk("s4_clear", state_code, 4'h0);
    eng_on = 1'b1;
    repeat (12) @(posedge CLK);
    #1;

    // Scenario 5: break prefix, reset mid EXP_B, stale done
    press(KB); press(KA);
    chk("s5_g_prior", disp_val, 4'h3);
    press(KF0); press(K9);
    chk("s5_break_g", disp_val, 4'h3);
    chk("s5_break_state", state_code, 4'h2);
    press(K9);  chk("s5_g_nine", disp_val, 4'h9);
    press(K3);  press(KA); press(KA); press(KC);
    chk("s5_exp_a", state_code, 4'h5);
    wait_state(4'h6, 40, found);
    chk("s5_exp_b_reached", found, 1'b1);
    @(posedge CLK); #1;
    dones_before = done_cnt;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    chk("s5_rst_state", state_code, 4'h0);
    chk("s5_rst_disp", disp_val, 4'h0);
    chk("s5_rst_ops", {mx_start, mx_base, mx_exp, mx_mod}, 13'h0);
    chk("s5_rst_flags", {key_match, err}, 2'b00);
    RST_N = 1'b1;
    repeat (15) @(posedge CLK);
    #1;
    chk("s5_stale_sent", done_cnt, dones_before + 1);
    chk("s5_stale_state", state_code, 4'h0);
    chk("s5_stale_disp", disp_val, 4'h0);
    chk("s5_stale_start", mx_start, 1'b0);

`ifdef KEY_VERIFY_EN
    // Scenario 6: corrupted fourth job -> mismatch
    job_cnt = 0;
    eng_corrupt = 1'b1;
    press(KB); press(K7); press(KA); press(K3); press(KA); press(K2);
    press(KA); press(K4); press(KC);
    wait_state(4'h9, 200, found);
    chk("s6_show_reached", found, 1'b1);
    chk("s6_err_pulse", err, 1'b1);
    chk("s6_match", key_match, 1'b0);
    @(posedge CLK); #1;
    chk("s6_err_drop", err, 1'b0);
    chk("s6_state_stay", state_code, 4'h9);
    chk("s6_match_hold", key_match, 1'b0);
    eng_corrupt = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
